// File: rtl/icosoc_kypd_pkg.sv
// Shared types and helpers for the PmodKYPD keypad peripheral.
// Scan states, register offsets, FIFO entry width and the key-code table.
package icosoc_kypd_pkg;

  typedef enum logic [1:0] {
    DRIVE,
    SAMPLE,
    EVAL
  } scan_state_t;

  localparam logic [15:0] REG_FIFO  = 16'h0000;
  localparam logic [15:0] REG_MAP   = 16'h0004;
  localparam logic [15:0] REG_FLUSH = 16'h0008;

  localparam int ENTRY_W = 5;

  // Key index is {row, col}; returns the legend printed on the keypad.
  function automatic logic [3:0] key_code(input logic [3:0] idx);
    logic [3:0] c;
    unique case (idx)
      4'd0:  c = 4'h1;
      4'd1:  c = 4'h2;
      4'd2:  c = 4'h3;
      4'd3:  c = 4'hA;
      4'd4:  c = 4'h4;
      4'd5:  c = 4'h5;
      4'd6:  c = 4'h6;
      4'd7:  c = 4'hB;
      4'd8:  c = 4'h7;
      4'd9:  c = 4'h8;
      4'd10: c = 4'h9;
      4'd11: c = 4'hC;
      4'd12: c = 4'h0;
      4'd13: c = 4'hF;
      4'd14: c = 4'hE;
      default: c = 4'hD;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/icosoc_kypd_fifo.sv
// Small synchronous FIFO for keypad events.
// A push into a full FIFO is accepted only when a pop happens that cycle.
module icosoc_kypd_fifo
  import icosoc_kypd_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = ENTRY_W,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  logic          do_pop;
  logic          do_push;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rp];

  // Storage needs no reset; only pointers define validity.
  always_ff @(posedge clk) begin
    if (do_push && !flush)
      mem[wp] <= din;
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else if (flush) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (do_push)
        wp <= wp + AW'(1);
      if (do_pop)
        rp <= rp + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/icosoc_mod_pmodkypd.sv
// icosoc ctrl-bus peripheral scanning a PmodKYPD 4x4 keypad.
// Define KYPD_RELEASE_EVENTS_EN to also queue key-release events.
module icosoc_mod_pmodkypd
  import icosoc_kypd_pkg::*;
#(
  parameter int CLOCK_FREQ_HZ  = 6000000,
  parameter int SETTLE_CYCLES  = 64,
  parameter int DEBOUNCE_SCANS = 4,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [3:0]  ctrl_wr,
  input  logic        ctrl_rd,
  input  logic [15:0] ctrl_addr,
  input  logic [31:0] ctrl_wdat,
  output logic [31:0] ctrl_rdat,
  output logic        ctrl_done,
  input  logic [7:0]  pins_in,
  output logic [7:0]  pins_out
);

  localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);
  localparam int FCW   = $clog2(FIFO_DEPTH) + 1;

  scan_state_t      state;
  scan_state_t      state_n;
  logic [1:0]       col;
  logic [1:0]       col_n;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_n;

  logic [15:0] raw;
  logic [15:0] raw_prev;
  logic [15:0] debounced;
  logic [15:0] pending;
  logic [15:0] clr_p;
  logic [3:0]  idx_p;
  logic [3:0]  stable_cnt;
  logic [3:0]  stable_n;
  logic        settled;
  logic        is_eval;
  logic        overflow;

  logic               push;
  logic [ENTRY_W-1:0] entry;
  logic [ENTRY_W-1:0] head;
  logic               full;
  logic               empty;
  logic [FCW-1:0]     fcount;

  logic        req;
  logic        pop;
  logic        flush;
  logic [31:0] rdat_n;
  logic        unused;

`ifdef KYPD_RELEASE_EVENTS_EN
  logic [15:0] rel_pending;
  logic [15:0] clr_r;
  logic [3:0]  idx_r;
`endif

  assign unused = ^{ctrl_wdat, pins_in[3:0], 32'(CLOCK_FREQ_HZ)};

  // Scan state register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= DRIVE;
      col   <= '0;
      cnt   <= '0;
    end else begin
      state <= state_n;
      col   <= col_n;
      cnt   <= cnt_n;
    end
  end

  // Scan sequencing: settle each column, sample, evaluate after col 3.
  always_comb begin
    state_n = state;
    col_n   = col;
    cnt_n   = cnt;
    unique case (state)
      DRIVE: begin
        if (cnt == CNT_W'(SETTLE_CYCLES - 1)) begin
          state_n = SAMPLE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      SAMPLE: begin
        if (col != 2'd3) begin
          col_n   = col + 2'd1;
          state_n = DRIVE;
        end else begin
          state_n = EVAL;
        end
      end
      EVAL: begin
        col_n   = '0;
        state_n = DRIVE;
      end
      default: state_n = DRIVE;
    endcase
  end

  // Column drive, registered so reset shows all pins high.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)
      pins_out <= 8'hFF;
    else if (state == EVAL)
      pins_out <= 8'hFF;
    else
      pins_out <= {4'hF, ~(4'b0001 << col)};
  end

  assign is_eval  = (state == EVAL);
  assign stable_n = (raw != raw_prev) ? 4'd0 :
                    (stable_cnt == 4'hF) ? stable_cnt :
                    stable_cnt + 4'd1;
  assign settled  = stable_n >= 4'(DEBOUNCE_SCANS - 1);

  // Pick the lowest pending press, then (optionally) release.
  always_comb begin
    push  = 1'b0;
    entry = '0;
    clr_p = '0;
    idx_p = '0;
    for (int i = 15; i >= 0; i--)
      if (pending[i])
        idx_p = 4'(i);
    if (|pending) begin
      push         = 1'b1;
      entry        = {1'b0, key_code(idx_p)};
      clr_p[idx_p] = 1'b1;
    end
`ifdef KYPD_RELEASE_EVENTS_EN
    clr_r = '0;
    idx_r = '0;
    for (int i = 15; i >= 0; i--)
      if (rel_pending[i])
        idx_r = 4'(i);
    if (!(|pending) && (|rel_pending)) begin
      push         = 1'b1;
      entry        = {1'b1, key_code(idx_r)};
      clr_r[idx_r] = 1'b1;
    end
`endif
  end

  // Row capture, debounce and event bookkeeping.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      raw         <= '0;
      raw_prev    <= '0;
      debounced   <= '0;
      pending     <= '0;
      stable_cnt  <= '0;
      overflow    <= 1'b0;
`ifdef KYPD_RELEASE_EVENTS_EN
      rel_pending <= '0;
`endif
    end else begin
      if (state == SAMPLE)
        for (int r = 0; r < 4; r++)
          raw[{r[1:0], col}] <= ~pins_in[4+r];
      if (is_eval) begin
        raw_prev   <= raw;
        stable_cnt <= stable_n;
        if (settled)
          debounced <= raw;
      end
      if (flush) begin
        pending  <= '0;
        overflow <= 1'b0;
      end else begin
        pending <= (pending & ~clr_p) |
                   ((is_eval && settled) ? (raw & ~debounced) : 16'h0);
        if (push && full && !pop)
          overflow <= 1'b1;
      end
`ifdef KYPD_RELEASE_EVENTS_EN
      if (flush)
        rel_pending <= '0;
      else
        rel_pending <= (rel_pending & ~clr_r) |
                       ((is_eval && settled) ? (~raw & debounced) : 16'h0);
`endif
    end
  end

  assign req   = !ctrl_done && (ctrl_rd || (|ctrl_wr));
  assign pop   = req && ctrl_rd && (ctrl_addr == REG_FIFO) && !empty;
  assign flush = req && (|ctrl_wr) && (ctrl_addr == REG_FLUSH);

  // Read data mux.
  always_comb begin
    rdat_n = '0;
    if (ctrl_rd) begin
      if (ctrl_addr == REG_FIFO)
        rdat_n = {!empty, overflow, 18'b0, 4'(fcount), 3'b0,
                  empty ? 5'b0 : head};
      else if (ctrl_addr == REG_MAP)
        rdat_n = {16'b0, debounced};
    end
  end

  // One-cycle completion pulse with data only in that cycle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ctrl_done <= 1'b0;
      ctrl_rdat <= '0;
    end else begin
      ctrl_done <= req;
      ctrl_rdat <= req ? rdat_n : 32'h0;
    end
  end

  icosoc_kypd_fifo #(
    .DEPTH(FIFO_DEPTH),
    .W    (ENTRY_W)
  ) u_fifo (
    .clk   (clk),
    .resetn(resetn),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .din   (entry),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (fcount)
  );

endmodule

// File: tb/tb_icosoc_mod_pmodkypd.sv
// Self-checking bench for icosoc_mod_pmodkypd.
// Keypad is modelled as a row/column switch matrix.
module tb_icosoc_mod_pmodkypd;

  localparam int SETTLE = 20;
  localparam int DEB    = 4;
  localparam int DEPTH  = 4;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [3:0]  ctrl_wr = '0;
  logic        ctrl_rd = 1'b0;
  logic [15:0] ctrl_addr = '0;
  logic [31:0] ctrl_wdat = '0;
  logic [31:0] ctrl_rdat;
  logic        ctrl_done;
  logic [7:0]  pins_in;
  logic [7:0]  pins_out;
  logic [15:0] keys = '0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  icosoc_mod_pmodkypd #(
    .CLOCK_FREQ_HZ (6000000),
    .SETTLE_CYCLES (SETTLE),
    .DEBOUNCE_SCANS(DEB),
    .FIFO_DEPTH    (DEPTH)
  ) dut (
    .clk      (clk),
    .resetn   (resetn),
    .ctrl_wr  (ctrl_wr),
    .ctrl_rd  (ctrl_rd),
    .ctrl_addr(ctrl_addr),
    .ctrl_wdat(ctrl_wdat),
    .ctrl_rdat(ctrl_rdat),
    .ctrl_done(ctrl_done),
    .pins_in  (pins_in),
    .pins_out (pins_out)
  );

  // A row reads low when a pressed key joins it to a low column.
  always_comb begin
    pins_in = 8'hFF;
    for (int r = 0; r < 4; r++)
      pins_in[4+r] = ~|(keys[r*4 +: 4] & ~pins_out[3:0]);
  end

  logic [3:0] ctab [16] = '{4'h1, 4'h2, 4'h3, 4'hA,
                            4'h4, 4'h5, 4'h6, 4'hB,
                            4'h7, 4'h8, 4'h9, 4'hC,
                            4'h0, 4'hF, 4'hE, 4'hD};

  logic [15:0] hist [$];
  logic [4:0]  mq [$];
  logic [15:0] mmap;
  logic        movf;

  task automatic model_reset();
    hist = {};
    hist.push_back(16'h0);
    mq   = {};
    mmap = '0;
    movf = 1'b0;
  endtask

  task automatic model_push(input logic [4:0] e);
    if (mq.size() < DEPTH) mq.push_back(e);
    else movf = 1'b1;
  endtask

  // Map follows a key pattern once the last DEB scans agree.
  task automatic model_scan(input logic [15:0] k);
    bit same;
    hist.push_back(k);
    if (hist.size() > DEB) void'(hist.pop_front());
    if (hist.size() == DEB) begin
      same = 1'b1;
      foreach (hist[i]) if (hist[i] != k) same = 1'b0;
      if (same) begin
        for (int i = 0; i < 16; i++)
          if (k[i] && !mmap[i]) model_push({1'b0, ctab[i]});
`ifdef KYPD_RELEASE_EVENTS_EN
        for (int i = 0; i < 16; i++)
          if (!k[i] && mmap[i]) model_push({1'b1, ctab[i]});
`endif
        mmap = k;
      end
    end
  endtask

  task automatic check(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", nm, got, exp);
    end
  endtask

  // Returns at the first cycle after an evaluation (all columns high).
  task automatic scan();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (pins_out !== 8'hFF && n < 1000);
    if (pins_out !== 8'hFF) begin
      errors++;
      $display("FAIL scan_timeout got %h expected ff", pins_out);
    end
    model_scan(keys);
  endtask

  task automatic hold(input logic [15:0] k, input int n);
    keys = k;
    repeat (n) scan();
  endtask

  task automatic bus_rd(input logic [15:0] a, output logic [31:0] d);
    int n = 0;
    @(negedge clk);
    ctrl_addr = a;
    ctrl_rd   = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (!ctrl_done && n < 8);
    d = ctrl_rdat;
    ctrl_rd = 1'b0;
    if (!ctrl_done) begin
      errors++;
      $display("FAIL rd_timeout got 0 expected 1");
    end
  endtask

  task automatic bus_wr(input logic [15:0] a);
    int n = 0;
    @(negedge clk);
    ctrl_addr = a;
    ctrl_wr   = 4'hF;
    do begin
      @(negedge clk);
      n++;
    end while (!ctrl_done && n < 8);
    ctrl_wr = 4'h0;
    if (!ctrl_done) begin
      errors++;
      $display("FAIL wr_timeout got 0 expected 1");
    end
    mq   = {};
    movf = 1'b0;
  endtask

  task automatic rd_check(input string nm, input logic [15:0] a,
                          input logic [31:0] exp);
    logic [31:0] d;
    bus_rd(a, d);
    check(nm, d, exp);
  endtask

  task automatic model_pop_check();
    logic [31:0] d;
    logic [31:0] e;
    if (mq.size() > 0)
      e = {1'b1, movf, 18'b0, 4'(mq.size()), 3'b0, mq[0]};
    else
      e = {1'b0, movf, 30'b0};
    if (mq.size() > 0) void'(mq.pop_front());
    bus_rd(16'h0000, d);
    check("rand_fifo", d, e);
  endtask

  task automatic do_reset();
    @(negedge clk);
    resetn  = 1'b0;
    keys    = '0;
    ctrl_rd = 1'b0;
    ctrl_wr = '0;
    repeat (3) @(negedge clk);
    check("rst_pins", {24'b0, pins_out}, 32'h0000_00FF);
    check("rst_done", {31'b0, ctrl_done}, 32'h0);
    check("rst_rdat", ctrl_rdat, 32'h0);
    resetn = 1'b1;
    model_reset();
  endtask

  typedef struct {
    logic [15:0] keys;
    int          scans;
    logic [15:0] map;
    logic [31:0] pop0;
    logic [31:0] pop1;
  } vec_t;

  vec_t tbl [7];

  initial begin
    logic [3:0] pat;
    int n;
    int len;

    tbl[0] = '{16'h0040, 5, 16'h0040, 32'h8000_0106, 32'h0};
    tbl[1] = '{16'h2001, 5, 16'h2001, 32'h8000_0201, 32'h8000_010F};
    tbl[2] = '{16'h8000, 5, 16'h8000, 32'h8000_010D, 32'h0};
    tbl[3] = '{16'h0480, 5, 16'h0480, 32'h8000_020B, 32'h8000_0109};
    tbl[4] = '{16'h1000, 5, 16'h1000, 32'h8000_0100, 32'h0};
    tbl[5] = '{16'h0010, 3, 16'h0000, 32'h0,         32'h0};
    tbl[6] = '{16'h0010, 4, 16'h0010, 32'h8000_0104, 32'h0};

    do_reset();

    for (int k = 0; k < 4; k++) begin
      pat = ~(4'b0001 << k);
      n = 0;
      while (pins_out[3:0] !== pat && n < 200) begin
        @(negedge clk);
        n++;
      end
      check("col_hi", {28'b0, pins_out[7:4]}, 32'hF);
      len = 0;
      while (pins_out[3:0] === pat && len < 200) begin
        len++;
        @(negedge clk);
      end
      check("col_len", len, SETTLE + 1);
    end
    rd_check("rst_fifo", 16'h0000, 32'h0);
    rd_check("rst_map", 16'h0004, 32'h0);
    rd_check("bad_addr", 16'h0010, 32'h0);
    repeat (30) @(negedge clk);
    do_reset();

    foreach (tbl[i]) begin
      hold(tbl[i].keys, tbl[i].scans);
      repeat (24) @(negedge clk);
      rd_check("tbl_map", 16'h0004, {16'b0, tbl[i].map});
      rd_check("tbl_pop0", 16'h0000, tbl[i].pop0);
      rd_check("tbl_pop1", 16'h0000, tbl[i].pop1);
      keys = '0;
      scan();
      hold(16'h0, 5);
      bus_wr(16'h0008);
      rd_check("tbl_flush", 16'h0000, 32'h0);
      scan();
    end

    for (int i = 0; i < 10; i++) begin
      keys = i[0] ? 16'h0100 : 16'h0;
      scan();
    end
    repeat (24) @(negedge clk);
    rd_check("bounce_map", 16'h0004, 32'h0);
    rd_check("bounce_fifo", 16'h0000, 32'h0);
    keys = '0;
    scan();
    hold(16'h0, 5);

    hold(16'h003F, 5);
    repeat (24) @(negedge clk);
    rd_check("ovf_head", 16'h0000, 32'hC000_0401);
    rd_check("ovf_next", 16'h0000, 32'hC000_0302);
    bus_wr(16'h0008);
    rd_check("ovf_flush", 16'h0000, 32'h0);
    keys = '0;
    scan();
    hold(16'h0, 5);
    bus_wr(16'h0008);
    scan();

    hold(16'h0008, 5);
    hold(16'h0000, 5);
    repeat (24) @(negedge clk);
`ifdef KYPD_RELEASE_EVENTS_EN
    rd_check("rel_press", 16'h0000, 32'h8000_020A);
    rd_check("rel_release", 16'h0000, 32'h8000_011A);
`else
    rd_check("rel_press", 16'h0000, 32'h8000_010A);
    rd_check("rel_none", 16'h0000, 32'h0);
`endif

    do_reset();
    for (int it = 0; it < 15; it++) begin
      hold(16'($urandom & $urandom & $urandom), $urandom_range(1, 6));
      repeat (24) @(negedge clk);
      rd_check("rand_map", 16'h0004, {16'b0, mmap});
      while (mq.size() > 0) model_pop_check();
      model_pop_check();
      if (it % 5 == 4) bus_wr(16'h0008);
      scan();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
